// File: rtl/uart_receiver_pkg.sv
// UART receiver shared definitions.
// Baud codes, divisor table, frame constants, FSM encoding.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int DEF_CLK_HZ = 50_000_000;

    localparam logic [2:0] BAUD_300    = 3'b000;
    localparam logic [2:0] BAUD_1200   = 3'b001;
    localparam logic [2:0] BAUD_4800   = 3'b010;
    localparam logic [2:0] BAUD_9600   = 3'b011;
    localparam logic [2:0] BAUD_19200  = 3'b100;
    localparam logic [2:0] BAUD_38400  = 3'b101;
    localparam logic [2:0] BAUD_57600  = 3'b110;
    localparam logic [2:0] BAUD_115200 = 3'b111;

    // Clocks per sample tick at 50 MHz, indexed by baud code.
    localparam logic [7:0][13:0] DIV_TABLE = {
        14'd27,  14'd54,   14'd81,   14'd163,
        14'd326, 14'd651,  14'd2604, 14'd10417
    };

    localparam logic [7:0][16:0] BAUD_TABLE = {
        17'd115200, 17'd57600, 17'd38400, 17'd19200,
        17'd9600,   17'd4800,  17'd1200,  17'd300
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Elaboration-time divisor table; other clocks get rounded values.
    function automatic logic [7:0][13:0] div_table(input int clk_hz);
        logic [7:0][13:0] t;
        int rate;
        int q;
        t = DIV_TABLE;
        if (clk_hz != DEF_CLK_HZ) begin
            for (int i = 0; i < 8; i++) begin
                rate = int'(BAUD_TABLE[i]);
                q = (clk_hz + rate * (OVERSAMPLE / 2))
                    / (rate * OVERSAMPLE);
                t[i] = q[13:0];
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver control/result bundle.
// master = receiver, slave = byte consumer.
interface uart_receiver_if;
    logic       Rx_EN;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    modport master (
        input  Rx_EN,
        output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR
    );

    modport slave (
        output Rx_EN,
        input  Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR
    );
endinterface

// File: rtl/uart_receiver_baud_controller.sv
// 16x oversample tick generator.
// Divider restarts whenever the rate code changes.
module baud_controller
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       reset,
    input  logic       clk,
    input  logic [2:0] baud_select,
    output logic       sample_ENABLE
);

    localparam logic [7:0][13:0] DIVS = div_table(CLK_HZ);

    logic [13:0] cnt_q, cnt_d;
    logic [2:0]  sel_q;
    logic        tick_q, tick_d;

    // Count 0..N-1 and tick on the last count.
    always_comb begin
        tick_d = 1'b0;
        cnt_d  = cnt_q + 14'd1;
        if (baud_select != sel_q) begin
            cnt_d = '0;
        end else if (cnt_q == DIVS[baud_select] - 14'd1) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Divider state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            sel_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sel_q  <= baud_select;
            tick_q <= tick_d;
        end
    end

    assign sample_ENABLE = tick_q;

endmodule

// File: rtl/uart_receiver.sv
// 8-E-1 UART receiver with 16x oversampling.
// Mid-bit sampling; parity/framing errors as one-cycle pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       RxD,
    uart_receiver_if.master rx
);

    localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    logic             tick;
    logic [NSYNC-1:0] sync_q;
    logic             rxd_s;

    rx_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       perr_q, perr_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       perror_q, perror_d;
    logic       ferror_q, ferror_d;

    baud_controller #(.CLK_HZ(CLK_HZ)) u_baud (
        .reset         (reset),
        .clk           (clk),
        .baud_select   (baud_select),
        .sample_ENABLE (tick)
    );

    // Line synchronizer; resets to the idle-high level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[NSYNC-2:0], RxD};
        end
    end

    assign rxd_s = sync_q[NSYNC-1];

    // Frame FSM; results are registered so flags land one clock after
    // the mid-stop sample tick.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        perror_d = 1'b0;
        ferror_d = 1'b0;
        if (!rx.Rx_EN) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = '0;
            perr_d  = 1'b0;
        end else if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        cnt_d   = '0;
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == TICK_MID) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rxd_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_DATA: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == TICK_LAST) begin
                        shift_d = {rxd_s, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == TICK_LAST) begin
                        perr_d  = (^shift_q) ^ rxd_s;
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == TICK_LAST) begin
                        if (!rxd_s) begin
                            ferror_d = 1'b1;
                            state_d  = ST_BREAK;
                        end else if (perr_q) begin
                            perror_d = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rxd_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            perr_q   <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            perror_q <= 1'b0;
            ferror_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            perr_q   <= perr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            perror_q <= perror_d;
            ferror_q <= ferror_d;
        end
    end

    assign rx.Rx_DATA   = data_q;
    assign rx.Rx_VALID  = valid_q;
    assign rx.Rx_PERROR = perror_q;
    assign rx.Rx_FERROR = ferror_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 115200 baud.
// Serial frames driven from tasks; pulses tallied by a monitor.
module tb_uart_receiver;

    localparam int CLK_P = 20;
    localparam int DIV   = 27;
    localparam int BIT_T = 16 * DIV * CLK_P;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] baud_select = 3'b111;
    logic       RxD = 1'b1;

    uart_receiver_if rxif ();

    uart_receiver #(
        .CLK_HZ      (50_000_000),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .RxD         (RxD),
        .rx          (rxif)
    );

    always #(CLK_P / 2) clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;
    int n_perr = 0;
    int n_ferr = 0;
    int n_multi = 0;
    int n_chg = 0;
    logic [7:0] rx_q[$];
    logic [7:0] prev_data;

    // Tally result pulses, one-hot flags and unannounced data changes.
    always @(negedge clk) begin
        if (rxif.Rx_VALID === 1'b1) begin
            n_valid <= n_valid + 1;
            rx_q.push_back(rxif.Rx_DATA);
        end
        if (rxif.Rx_PERROR === 1'b1) n_perr <= n_perr + 1;
        if (rxif.Rx_FERROR === 1'b1) n_ferr <= n_ferr + 1;
        if (32'(rxif.Rx_VALID) + 32'(rxif.Rx_PERROR)
            + 32'(rxif.Rx_FERROR) > 1)
            n_multi <= n_multi + 1;
        if (reset && rxif.Rx_DATA !== prev_data
            && rxif.Rx_VALID !== 1'b1)
            n_chg <= n_chg + 1;
        prev_data <= rxif.Rx_DATA;
    end

    task automatic drive_bit(input logic b);
        RxD = b;
        #(BIT_T);
    endtask

    task automatic send_frame(input logic [7:0] d,
                              input logic p, input logic s);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
        RxD = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        RxD = 1'b1;
        rxif.Rx_EN = 1'b1;
        #400;
        n_cmp++;
        if (rxif.Rx_DATA !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 00", rxif.Rx_DATA);
        end
        n_cmp++;
        if (rxif.Rx_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b want 0", rxif.Rx_VALID);
        end
        n_cmp++;
        if (rxif.Rx_PERROR !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_perr: got %b want 0", rxif.Rx_PERROR);
        end
        n_cmp++;
        if (rxif.Rx_FERROR !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ferr: got %b want 0", rxif.Rx_FERROR);
        end
        reset = 1'b1;
        #(BIT_T);
    endtask

    task automatic check_frame(input string nm, input int v0,
                               input int p0, input int f0,
                               input int dv, input int dp,
                               input int df, input logic [7:0] dat);
        n_cmp++;
        if (n_valid - v0 !== dv) begin
            n_bad++;
            $display("FAIL %s_valid: got %0d pulses want %0d",
                     nm, n_valid - v0, dv);
        end
        n_cmp++;
        if (n_perr - p0 !== dp) begin
            n_bad++;
            $display("FAIL %s_perr: got %0d pulses want %0d",
                     nm, n_perr - p0, dp);
        end
        n_cmp++;
        if (n_ferr - f0 !== df) begin
            n_bad++;
            $display("FAIL %s_ferr: got %0d pulses want %0d",
                     nm, n_ferr - f0, df);
        end
        n_cmp++;
        if (rxif.Rx_DATA !== dat) begin
            n_bad++;
            $display("FAIL %s_data: got %h want %h",
                     nm, rxif.Rx_DATA, dat);
        end
    endtask

    task automatic test_good_byte();
        int v0, p0, f0;
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame(8'h99, 1'b0, 1'b1);
        check_frame("good", v0, p0, f0, 1, 0, 0, 8'h99);
    endtask

    task automatic test_parity_error();
        int v0, p0, f0;
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame(8'h99, 1'b1, 1'b1);
        send_frame(8'h0E, 1'b0, 1'b1);
        check_frame("parity", v0, p0, f0, 0, 2, 0, 8'h99);
    endtask

    task automatic test_framing_break();
        int v0, p0, f0;
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(i inside {2, 3, 4, 5});
        drive_bit(1'b1);
        RxD = 1'b0;
        #(3 * 11 * BIT_T);
        check_frame("break", v0, p0, f0, 0, 0, 1, 8'h99);
        RxD = 1'b1;
        #(2 * BIT_T);
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame(8'h55, 1'b0, 1'b1);
        check_frame("after_break", v0, p0, f0, 1, 0, 0, 8'h55);
    endtask

    task automatic test_glitch();
        int v0, p0, f0;
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        RxD = 1'b0;
        #(4 * DIV * CLK_P);
        RxD = 1'b1;
        #(BIT_T);
        send_frame(8'h24, 1'b0, 1'b1);
        check_frame("glitch", v0, p0, f0, 1, 0, 0, 8'h24);
    endtask

    task automatic test_abort_reset();
        int v0, p0, f0;
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        reset = 1'b0;
        RxD = 1'b1;
        #400;
        n_cmp++;
        if (rxif.Rx_DATA !== 8'h00) begin
            n_bad++;
            $display("FAIL abort_rst_data: got %h want 00",
                     rxif.Rx_DATA);
        end
        reset = 1'b1;
        #(2 * BIT_T);
        send_frame(8'h81, 1'b0, 1'b1);
        check_frame("abort_rst", v0, p0, f0, 1, 0, 0, 8'h81);
    endtask

    task automatic test_abort_enable();
        int v0, p0, f0;
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rxif.Rx_EN = 1'b0;
        RxD = 1'b1;
        #(2 * BIT_T);
        rxif.Rx_EN = 1'b1;
        #(BIT_T);
        check_frame("abort_en", v0, p0, f0, 0, 0, 0, 8'h81);
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame(8'hC3, 1'b0, 1'b1);
        check_frame("after_en", v0, p0, f0, 1, 0, 0, 8'hC3);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        logic [7:0] got;
        int v0, q0;
        exp_b[0] = 8'h00;
        exp_b[1] = 8'hFF;
        exp_b[2] = 8'hA5;
        v0 = n_valid;
        q0 = rx_q.size();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b1);
        #(BIT_T);
        n_cmp++;
        if (n_valid - v0 !== 3) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d pulses want 3",
                     n_valid - v0);
        end
        for (int i = 0; i < 3; i++) begin
            got = (rx_q.size() > q0 + i) ? rx_q[q0 + i] : 8'hxx;
            n_cmp++;
            if (got !== exp_b[i]) begin
                n_bad++;
                $display("FAIL b2b_byte%0d: got %h want %h",
                         i, got, exp_b[i]);
            end
        end
    endtask

    task automatic test_monitors();
        n_cmp++;
        if (n_multi !== 0) begin
            n_bad++;
            $display("FAIL one_hot_flags: got %0d overlaps want 0",
                     n_multi);
        end
        n_cmp++;
        if (n_chg !== 0) begin
            n_bad++;
            $display("FAIL data_stable: got %0d changes want 0",
                     n_chg);
        end
    endtask

    initial begin
        test_reset();
        test_good_byte();
        test_parity_error();
        test_framing_break();
        test_glitch();
        test_abort_reset();
        test_abort_enable();
        test_back_to_back();
        test_monitors();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
